// File: rtl/wb_rx_fifo_pkg.sv
// Shared register map and bit positions for the wb_rx_fifo receive buffer.
// Imported by the FIFO core and the Wishbone front end.
package types;

  localparam int REG_DATA   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_COUNT  = 2;
  localparam int REG_CTRL   = 3;
  localparam int REG_THRESH = 4;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_RXERR   = 3;
  localparam int ST_IRQ     = 4;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  function automatic int cnt_bits(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/wb_rx_fifo_if.sv
// Wishbone slave bundle for wb_rx_fifo.
// master drives the request side, slave returns data and ack.
interface wb_rx_fifo_if #(
  parameter int addr_width = 4,
  parameter int data_width = 8
);

  logic [addr_width-1:0] addr;
  logic [data_width-1:0] data_m;
  logic [data_width-1:0] data_s;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  ack;

  modport master (
    output addr,
    output data_m,
    output cyc,
    output stb,
    output we,
    input  data_s,
    input  ack
  );

  modport slave (
    input  addr,
    input  data_m,
    input  cyc,
    input  stb,
    input  we,
    output data_s,
    output ack
  );

endinterface

// File: rtl/wb_rx_fifo_sync_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count.
// A push while full is accepted only when a pop frees a slot that cycle.
module sync_fifo
  import types::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [data_width-1:0]    wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [data_width-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_bits(depth)-1:0] count
);

  localparam int AW = $clog2(depth);
  localparam int CW = cnt_bits(depth);

  logic [data_width-1:0] mem_q [depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign rd_en = pop & ~empty & ~flush;
  assign wr_en = push & ~flush & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_rx_fifo.sv
// RX byte-stream buffer with Wishbone register front end.
// Optional threshold interrupt built when WB_RX_FIFO_IRQ_EN is defined.
module wb_rx_fifo
  import types::*;
#(
  parameter int addr_width = 4,
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_error,
  wb_rx_fifo_if.slave           bus,
  output logic                  irq
);

  localparam int CW = cnt_bits(depth);

  logic                  ack_q, ack_d;
  logic [data_width-1:0] data_s_q, data_s_d;
  logic                  overrun_q, overrun_d;
  logic                  rx_err_q, rx_err_d;

  logic [data_width-1:0] head;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;

  logic req, rd_req, wr_req;
  logic sel_data, sel_status, sel_count;
  logic sel_ctrl, sel_thresh;
  logic pop, ctrl_wr, flush, clr;
  logic irq_pend;
  logic [2:0]            ctrl_rd;
  logic [CW-1:0]         thresh_rd;
  logic [7:0]            status;
  logic [data_width-1:0] rd_val;
  logic                  unused_wdata;

  assign unused_wdata = ^bus.data_m;

  // A new request is taken only while ack is low: ack every other cycle.
  assign req    = bus.cyc & bus.stb & ~ack_q;
  assign rd_req = req & ~bus.we;
  assign wr_req = req & bus.we;

  assign sel_data   = (bus.addr == addr_width'(REG_DATA));
  assign sel_status = (bus.addr == addr_width'(REG_STATUS));
  assign sel_count  = (bus.addr == addr_width'(REG_COUNT));
  assign sel_ctrl   = (bus.addr == addr_width'(REG_CTRL));
  assign sel_thresh = (bus.addr == addr_width'(REG_THRESH));

  assign pop     = rd_req & sel_data & ~empty;
  assign ctrl_wr = wr_req & sel_ctrl;
  assign flush   = ctrl_wr & bus.data_m[CTRL_FLUSH];
  assign clr     = ctrl_wr & bus.data_m[CTRL_CLEAR];

  sync_fifo #(
    .data_width (data_width),
    .depth      (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef WB_RX_FIFO_IRQ_EN
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [CW-1:0] thresh_q, thresh_d;

  assign irq_pend  = irq_en_q & ((count >= thresh_q) | overrun_q);
  assign ctrl_rd   = {irq_en_q, 2'b00};
  assign thresh_rd = thresh_q;
  assign irq       = irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    irq_d    = irq_pend;
    if (ctrl_wr) irq_en_d = bus.data_m[CTRL_IRQ_EN];
    if (wr_req & sel_thresh) thresh_d = bus.data_m[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      thresh_q <= CW'(depth / 2);
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
    end
  end
`else
  assign irq_pend  = 1'b0;
  assign ctrl_rd   = '0;
  assign thresh_rd = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    status             = '0;
    status[ST_EMPTY]   = empty;
    status[ST_FULL]    = full;
    status[ST_OVERRUN] = overrun_q;
    status[ST_RXERR]   = rx_err_q;
    status[ST_IRQ]     = irq_pend;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_data:   rd_val = empty ? '0 : head;
      sel_status: rd_val = data_width'(status);
      sel_count:  rd_val = data_width'(count);
      sel_ctrl:   rd_val = data_width'(ctrl_rd);
      sel_thresh: rd_val = data_width'(thresh_rd);
      default:    rd_val = '0;
    endcase
  end

  // A flushed push and a popped-while-full push never count as overrun;
  // a fresh event outranks a same-cycle clear.
  always_comb begin
    ack_d     = req;
    data_s_d  = rd_req ? rd_val : data_s_q;
    overrun_d = (rx_valid & ~flush & full & ~pop) | (overrun_q & ~clr);
    rx_err_d  = rx_error | (rx_err_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      data_s_q  <= '0;
      overrun_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      data_s_q  <= data_s_d;
      overrun_q <= overrun_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.data_s = data_s_q;

endmodule

// File: tb/tb_wb_rx_fifo.sv
// Self-checking bench for wb_rx_fifo: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_wb_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       irq;

  wb_rx_fifo_if #(.addr_width(4), .data_width(8)) bus ();

  always #5 clk = ~clk;

  wb_rx_fifo #(
    .addr_width (4),
    .data_width (8),
    .depth      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .bus      (bus),
    .irq      (irq)
  );

  int tests = 0;
  int fails = 0;

  byte unsigned q[$];
  bit ov, er, ien;
  int th;

  typedef struct {
    int         kind;
    int         a;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    ov = 0;
    er = 0;
    ien = 0;
    th = DEPTH / 2;
  endfunction

  function automatic void m_push(input byte unsigned d);
    if (q.size() < DEPTH) q.push_back(d);
    else ov = 1;
  endfunction

  function automatic logic [7:0] m_status();
    bit ip;
    ip = 0;
`ifdef WB_RX_FIFO_IRQ_EN
    ip = ien && ((q.size() >= th) || ov);
`endif
    return {3'b000, ip, er, ov, q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic logic [7:0] m_read(input int a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      0: if (q.size() > 0) r = q.pop_front();
      1: r = m_status();
      2: r = 8'(q.size());
`ifdef WB_RX_FIFO_IRQ_EN
      3: r = {5'b0, ien, 2'b00};
      4: r = 8'(th);
`endif
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic void m_write(input int a, input logic [7:0] wd,
                                  input bit push, input logic [7:0] pd);
    bit fl;
    fl = 0;
    if (a == 3) begin
      fl = wd[0];
      if (fl) q.delete();
      if (wd[1]) begin
        ov = 0;
        er = 0;
      end
`ifdef WB_RX_FIFO_IRQ_EN
      ien = wd[2];
`endif
    end
`ifdef WB_RX_FIFO_IRQ_EN
    if (a == 4) th = int'(wd[4:0]);
`endif
    if (push && !fl) m_push(pd);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic push_word(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic err_pulse();
    @(negedge clk);
    rx_error = 1;
    @(negedge clk);
    rx_error = 0;
  endtask

  // One Wishbone transfer; an optional RX push rides the request cycle.
  task automatic bus_op(input bit wr, input int a, input logic [7:0] wd,
                        input bit push, input logic [7:0] pd,
                        output logic [7:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    bus.addr   = 4'(a);
    bus.we     = wr;
    bus.data_m = wd;
    bus.cyc    = 1;
    bus.stb    = 1;
    rx_valid   = push;
    rx_data    = pd;
    @(posedge clk);
    #1;
    rx_valid = 0;
    while (!bus.ack && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ack_latency", n, 0);
    rd      = bus.data_s;
    bus.cyc = 0;
    bus.stb = 0;
    bus.we  = 0;
    @(posedge clk);
    #1;
    check("ack_one_cycle", bus.ack, 1'b0);
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [7:0] exp);
    logic [7:0] r;
    bus_op(0, a, 8'h00, 0, 8'h00, r);
    check(nm, r, exp);
  endtask

  task automatic wr_reg(input int a, input logic [7:0] wd, input bit push,
                        input logic [7:0] pd);
    logic [7:0] r;
    bus_op(1, a, wd, push, pd, r);
  endtask

  task automatic add(input int k, input int a, input logic [7:0] wd,
                     input logic [7:0] exp);
    vec_t v;
    v.kind = k;
    v.a    = a;
    v.wd   = wd;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] r, e;
    int acks;

    rst        = 1;
    rx_valid   = 0;
    rx_error   = 0;
    rx_data    = 0;
    bus.addr   = 0;
    bus.data_m = 0;
    bus.cyc    = 0;
    bus.stb    = 0;
    bus.we     = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 1'b0);
    check("rst_data_s", bus.data_s, 8'h00);
    check("rst_irq", irq, 1'b0);
    rst = 0;

    // kind: 0 read-and-compare, 1 write, 2 RX push
    add(0, 1, 8'h00, 8'h01);
    add(0, 2, 8'h00, 8'h00);
    add(2, 0, 8'h11, 8'h00);
    add(2, 0, 8'h22, 8'h00);
    add(2, 0, 8'h33, 8'h00);
    add(0, 2, 8'h00, 8'h03);
    add(0, 0, 8'h00, 8'h11);
    add(0, 0, 8'h00, 8'h22);
    add(0, 0, 8'h00, 8'h33);
    add(0, 0, 8'h00, 8'h00);
    add(0, 1, 8'h00, 8'h01);
    add(0, 7, 8'h00, 8'h00);
    add(1, 0, 8'hff, 8'h00);
    add(1, 2, 8'h05, 8'h00);
    add(0, 2, 8'h00, 8'h00);
    add(0, 3, 8'h00, 8'h00);
`ifdef WB_RX_FIFO_IRQ_EN
    add(0, 4, 8'h00, 8'h08);
`else
    add(0, 4, 8'h00, 8'h00);
`endif

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        0: rd_chk($sformatf("vec%0d_a%0d", i, tbl[i].a), tbl[i].a, tbl[i].exp);
        1: wr_reg(tbl[i].a, tbl[i].wd, 0, 8'h00);
        default: push_word(tbl[i].wd);
      endcase
    end

    // held cyc&stb: ack every second cycle
    @(negedge clk);
    bus.addr = 4'd2;
    bus.we   = 0;
    bus.cyc  = 1;
    bus.stb  = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack) acks++;
    end
    bus.cyc = 0;
    bus.stb = 0;
    check("b2b_acks", acks, 3);
    @(posedge clk);
    #1;

    // overflow, sticky overrun, clear and wrap
    do_reset();
    for (int i = 0; i <= DEPTH; i++) push_word(8'(8'h40 + i));
    rd_chk("full_count", 2, 8'd16);
    rd_chk("full_status", 1, 8'h06);
    check("full_irq", irq, 1'b0);
    wr_reg(3, 8'h02, 1, 8'h99);
    rd_chk("clr_vs_event", 1, 8'h06);
    wr_reg(3, 8'h02, 0, 8'h00);
    rd_chk("clr_status", 1, 8'h02);
    bus_op(0, 0, 8'h00, 1, 8'hA0, r);
    check("pop_push_full", r, 8'h40);
    rd_chk("pop_push_count", 2, 8'd16);
    rd_chk("pop_push_status", 1, 8'h02);
    for (int i = 1; i < DEPTH; i++) rd_chk($sformatf("wrap%0d", i), 0, 8'(8'h40 + i));
    rd_chk("wrap_last", 0, 8'hA0);
    rd_chk("drained", 1, 8'h01);

    // flush with coincident push
    push_word(8'h51);
    push_word(8'h52);
    wr_reg(3, 8'h01, 1, 8'h55);
    rd_chk("flush_count", 2, 8'd0);
    rd_chk("flush_status", 1, 8'h01);
    rd_chk("flush_data", 0, 8'h00);

    // rx_error sticky without pushing
    err_pulse();
    rd_chk("rxerr_status", 1, 8'h09);
    wr_reg(3, 8'h02, 0, 8'h00);
    rd_chk("rxerr_clr", 1, 8'h01);

    // reset while ack is up
    push_word(8'h61);
    push_word(8'h62);
    @(negedge clk);
    bus.addr = 4'd2;
    bus.we   = 0;
    bus.cyc  = 1;
    bus.stb  = 1;
    @(posedge clk);
    #1;
    check("pre_rst_ack", bus.ack, 1'b1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check("mid_rst_ack", bus.ack, 1'b0);
    @(negedge clk);
    bus.cyc = 0;
    bus.stb = 0;
    rst = 0;
    m_reset();
    rd_chk("mid_rst_count", 2, 8'd0);

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [7:0] d;
      k = $urandom_range(0, 10);
      d = 8'($urandom);
      case (k)
        0, 1, 2, 3: begin
          push_word(d);
          m_push(d);
        end
        4, 5: begin
          bit p;
          p = 1'($urandom);
          bus_op(0, 0, 8'h00, p, d, r);
          e = m_read(0);
          if (p) m_push(d);
          check($sformatf("rnd%0d_data", i), r, e);
        end
        6, 7: begin
          int a;
          a = $urandom_range(1, 9);
          bus_op(0, a, 8'h00, 0, 8'h00, r);
          e = m_read(a);
          check($sformatf("rnd%0d_a%0d", i, a), r, e);
        end
        8: begin
          err_pulse();
          er = 1;
        end
        default: begin
          bit p;
          logic [7:0] w;
          p = 1'($urandom);
          w = 8'($urandom_range(0, 3));
          bus_op(1, 3, w, p, d, r);
          m_write(3, w, p, d);
        end
      endcase
    end
    rd_chk("rnd_final_count", 2, 8'(q.size()));
    rd_chk("rnd_final_status", 1, m_status());

`ifdef WB_RX_FIFO_IRQ_EN
    do_reset();
    wr_reg(4, 8'h04, 0, 8'h00);
    wr_reg(3, 8'h04, 0, 8'h00);
    rd_chk("ctrl_rd", 3, 8'h04);
    rd_chk("thresh_rd", 4, 8'h04);
    for (int i = 0; i < 4; i++) push_word(8'(8'h70 + i));
    check("irq_latency", irq, 1'b0);
    @(posedge clk);
    #1;
    check("irq_set", irq, 1'b1);
    rd_chk("irq_status", 1, 8'h10);
    rd_chk("irq_pop", 0, 8'h70);
    check("irq_clear", irq, 1'b0);
`else
    check("irq_tied", irq, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
